// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line in, acknowledge in, received byte and status out.
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       busy;

  // Side that drives the line and consumes bytes
  modport master (
    output rx,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  rx_overrun,
    input  frame_err,
    input  busy
  );

  // Receiver side
  modport slave (
    input  rx,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output rx_overrun,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Start bit is verified at its midpoint, data and stop bits
// are then sampled one bit period apart. A low stop bit raises a one-cycle
// frame error and the receiver waits for the line to return high before it
// looks for the next start bit.
module uart_rx #(
  parameter int clock_frequency = 12000000,
  parameter int uart_baud_rate  = 9600
) (
  input  logic    clk,
  input  logic    rst,
  uart_rx_if.slave bus
);

  localparam int BIT_TICKS  = clock_frequency / uart_baud_rate;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Line synchronizer stages; both idle high so reset never looks like a start bit
  logic rx_p0;
  logic rx_p1;
  logic rx_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             valid_q, valid_nxt;
  logic             ovr_q, ovr_nxt;
  logic             ferr_q, ferr_nxt;
  logic             done;

  assign rx_s = rx_p1;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  // FSM, counters, shift register and output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ovr_q   <= ovr_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  // Next-state, sampling and handshake decisions
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    ovr_nxt   = ovr_q;
    ferr_nxt  = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          // A line already back high at mid start bit is treated as noise
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // A completing byte wins over an acknowledge; an acknowledge in the same
    // cycle only suppresses the overrun, since the old byte was consumed.
    if (done) begin
      data_nxt  = shreg;
      valid_nxt = 1'b1;
      ovr_nxt   = valid_q && !bus.rx_ack;
    end else if (bus.rx_ack && valid_q) begin
      valid_nxt = 1'b0;
      ovr_nxt   = 1'b0;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.rx_overrun = ovr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at default rates for the nominal
// latency and glitch cases, one at a scaled clock for the handshake cases.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int D_BIT  = 1250;
  localparam int D_HALF = 625;
  localparam int F_BIT  = 100;
  localparam int F_HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int   cyc     = 0;
  int   d_fe    = 0;
  int   d_vrise = 0;
  int   f_fe    = 0;
  int   f_vrise = 0;
  int   f_vfall = 0;
  logic d_vprev = 1'b0;
  logic f_vprev = 1'b0;

  uart_rx_if bd();
  uart_rx_if bf();

  uart_rx u_dflt (
    .clk (clk),
    .rst (rst),
    .bus (bd)
  );

  uart_rx #(
    .clock_frequency (960000),
    .uart_baud_rate  (9600)
  ) u_fast (
    .clk (clk),
    .rst (rst),
    .bus (bf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    d_vprev <= bd.rx_valid;
    f_vprev <= bf.rx_valid;
    if (bd.frame_err === 1'b1) d_fe <= d_fe + 1;
    if (bf.frame_err === 1'b1) f_fe <= f_fe + 1;
    if (bd.rx_valid === 1'b1 && d_vprev === 1'b0) d_vrise <= d_vrise + 1;
    if (bf.rx_valid === 1'b1 && f_vprev === 1'b0) f_vrise <= f_vrise + 1;
    if (bf.rx_valid === 1'b0 && f_vprev === 1'b1) f_vfall <= f_vfall + 1;
  end

  task automatic set_rx(input bit sel, input logic v);
    if (sel) bf.rx = v;
    else     bd.rx = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v);
    int bt;
    bt = sel ? F_BIT : D_BIT;
    set_rx(sel, 1'b0);
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      repeat (bt) @(negedge clk);
    end
    set_rx(sel, stop_v);
    repeat (bt) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    obs = {bd.rx_data, bd.rx_valid, bd.rx_overrun, bd.frame_err, bd.busy};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_dflt: outputs %h expected 000", obs);
    end
    obs = {bf.rx_data, bf.rx_valid, bf.rx_overrun, bf.frame_err, bf.busy};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_fast: outputs %h expected 000", obs);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bd.busy !== 1'b0 || bf.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: dflt %b fast %b expected 0", bd.busy, bf.busy);
    end
  endtask

  task automatic test_nominal();
    int t0, lat, fe0;
    bit got;
    got = 1'b0;
    lat = 0;
    fe0 = d_fe;
    t0  = cyc;
    fork
      send_frame(1'b0, 8'hA5, 1'b1);
      begin
        for (int n = 0; n < 13000; n++) begin
          @(negedge clk);
          if (bd.rx_valid === 1'b1) begin
            got = 1'b1;
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    checks++;
    if (!got || lat < 11876 || lat > 11878) begin
      errors++;
      $display("FAIL nominal_latency: got %0d (seen %0b) expected 11877 +/-1", lat, got);
    end
    checks++;
    if (bd.rx_data !== 8'hA5 || bd.rx_valid !== 1'b1 || bd.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL nominal_data: data %h valid %b ovr %b expected a5 1 0",
               bd.rx_data, bd.rx_valid, bd.rx_overrun);
    end
    checks++;
    if (d_fe != fe0 || bd.busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_ferr_busy: ferr cycles %0d busy %b expected 0 0", d_fe - fe0, bd.busy);
    end
    bd.rx_ack = 1'b1;
    @(negedge clk);
    bd.rx_ack = 1'b0;
    checks++;
    if (bd.rx_valid !== 1'b0 || bd.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL nominal_ack: valid %b ovr %b expected 0 0", bd.rx_valid, bd.rx_overrun);
    end
    bd.rx_ack = 1'b1;
    @(negedge clk);
    bd.rx_ack = 1'b0;
    checks++;
    if (bd.rx_valid !== 1'b0 || bd.rx_overrun !== 1'b0 || bd.rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL idle_ack: valid %b ovr %b data %h expected 0 0 a5",
               bd.rx_valid, bd.rx_overrun, bd.rx_data);
    end
  endtask

  task automatic test_glitch();
    int fe0, vr0;
    fe0 = d_fe;
    vr0 = d_vrise;
    bd.rx = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (bd.busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high: busy %b expected 1", bd.busy);
    end
    bd.rx = 1'b1;
    repeat (D_HALF + 100) @(negedge clk);
    checks++;
    if (bd.busy !== 1'b0 || bd.rx_valid !== 1'b0 || d_fe != fe0 || d_vrise != vr0) begin
      errors++;
      $display("FAIL glitch_reject: busy %b valid %b ferr %0d vrise %0d expected 0 0 0 0",
               bd.busy, bd.rx_valid, d_fe - fe0, d_vrise - vr0);
    end
  endtask

  task automatic test_overrun();
    send_frame(1'b1, 8'h11, 1'b1);
    checks++;
    if (bf.rx_data !== 8'h11 || bf.rx_valid !== 1'b1 || bf.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: data %h valid %b ovr %b expected 11 1 0",
               bf.rx_data, bf.rx_valid, bf.rx_overrun);
    end
    send_frame(1'b1, 8'h22, 1'b1);
    checks++;
    if (bf.rx_data !== 8'h22 || bf.rx_valid !== 1'b1 || bf.rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_second: data %h valid %b ovr %b expected 22 1 1",
               bf.rx_data, bf.rx_valid, bf.rx_overrun);
    end
    bf.rx_ack = 1'b1;
    @(negedge clk);
    bf.rx_ack = 1'b0;
    checks++;
    if (bf.rx_valid !== 1'b0 || bf.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_ack: valid %b ovr %b expected 0 0", bf.rx_valid, bf.rx_overrun);
    end
  endtask

  task automatic test_simul_ack();
    int vf0;
    send_frame(1'b1, 8'h22, 1'b1);
    checks++;
    if (bf.rx_data !== 8'h22 || bf.rx_valid !== 1'b1 || bf.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_pending: data %h valid %b ovr %b expected 22 1 0",
               bf.rx_data, bf.rx_valid, bf.rx_overrun);
    end
    vf0 = f_vfall;
    fork
      send_frame(1'b1, 8'h33, 1'b1);
      begin
        repeat (2 + F_HALF + 9 * F_BIT) @(negedge clk);
        bf.rx_ack = 1'b1;
        @(negedge clk);
        bf.rx_ack = 1'b0;
        checks++;
        if (bf.rx_data !== 8'h33 || bf.rx_valid !== 1'b1 || bf.rx_overrun !== 1'b0) begin
          errors++;
          $display("FAIL simul_ack: data %h valid %b ovr %b expected 33 1 0",
                   bf.rx_data, bf.rx_valid, bf.rx_overrun);
        end
      end
    join
    checks++;
    if (f_vfall != vf0) begin
      errors++;
      $display("FAIL simul_no_drop: valid fell %0d times expected 0", f_vfall - vf0);
    end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = f_fe;
    send_frame(1'b1, 8'h0F, 1'b0);
    repeat (5000) @(negedge clk);
    checks++;
    if (f_fe != fe0 + 1) begin
      errors++;
      $display("FAIL frame_err_pulse: cycles high %0d expected 1", f_fe - fe0);
    end
    checks++;
    if (bf.busy !== 1'b1 || bf.rx_data !== 8'h33 || bf.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: busy %b data %h valid %b expected 1 33 1",
               bf.busy, bf.rx_data, bf.rx_valid);
    end
    bf.rx = 1'b1;
    repeat (2 * F_BIT) @(negedge clk);
    checks++;
    if (bf.busy !== 1'b0) begin
      errors++;
      $display("FAIL break_release: busy %b expected 0", bf.busy);
    end
    send_frame(1'b1, 8'h5A, 1'b1);
    checks++;
    if (bf.rx_data !== 8'h5A || bf.rx_valid !== 1'b1 || f_fe != fe0 + 1) begin
      errors++;
      $display("FAIL after_break: data %h valid %b ferr %0d expected 5a 1 1",
               bf.rx_data, bf.rx_valid, f_fe - fe0);
    end
  endtask

  task automatic test_reset_mid();
    int fe0, vr0;
    logic [7:0] b;
    logic [11:0] obs;
    bf.rx_ack = 1'b1;
    @(negedge clk);
    bf.rx_ack = 1'b0;
    fe0 = f_fe;
    vr0 = f_vrise;
    b = 8'h77;
    bf.rx = 1'b0;
    repeat (F_BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bf.rx = b[i];
      repeat (F_BIT) @(negedge clk);
    end
    bf.rx = b[4];
    repeat (F_HALF) @(negedge clk);
    checks++;
    if (bf.busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy %b expected 1", bf.busy);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    obs = {bf.rx_data, bf.rx_valid, bf.rx_overrun, bf.frame_err, bf.busy};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset: outputs %h expected 000", obs);
    end
    rst = 1'b0;
    repeat (3 * F_BIT) @(negedge clk);
    checks++;
    if (bf.busy !== 1'b0 || f_vrise != vr0 || f_fe != fe0) begin
      errors++;
      $display("FAIL aborted_frame: busy %b vrise %0d ferr %0d expected 0 0 0",
               bf.busy, f_vrise - vr0, f_fe - fe0);
    end
    send_frame(1'b1, 8'hC3, 1'b1);
    checks++;
    if (bf.rx_data !== 8'hC3 || bf.rx_valid !== 1'b1 || bf.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame: data %h valid %b ovr %b expected c3 1 0",
               bf.rx_data, bf.rx_valid, bf.rx_overrun);
    end
  endtask

  initial begin
    bd.rx = 1'b1;
    bd.rx_ack = 1'b0;
    bf.rx = 1'b1;
    bf.rx_ack = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_overrun();
    test_simul_ack();
    test_framing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clock_frequency, default 12000000: system clock frequency in Hz.
REQ-002 Parameter uart_baud_rate, default 9600: line bit rate in baud, frame format 8N1.
REQ-003 Port clk  input  1: single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port rx  input  1: asynchronous serial line; idle high.
REQ-006 Port rx_ack  input  1: consumer acknowledge; clears rx_valid and rx_overrun.
REQ-007 Port rx_data  output  8: last correctly framed byte.
REQ-008 Port rx_valid  output  1: rx_data holds an unacknowledged byte.
REQ-009 Port rx_overrun  output  1: sticky; a byte was overwritten before being acknowledged.
REQ-010 Port frame_err  output  1: one-cycle pulse on a bad stop bit.
REQ-011 Port busy  output  1: high in every state except IDLE.

Function
REQ-012 Derived constants SHALL use integer division: BIT_TICKS = clock_frequency/uart_baud_rate, giving 1250 at defaults; HALF_TICKS = BIT_TICKS/2, giving 625.
REQ-013 rx SHALL pass through a two-flop synchronizer before use; rx_s denotes the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK and one tick counter of width clog2(BIT_TICKS).
REQ-015 IDLE: when rx_s=0, move to START and clear the counter.
REQ-016 START: at count HALF_TICKS-1, if rx_s=0 move to DATA with counter and bit index cleared; if rx_s=1 return to IDLE as a glitch, with no output change.
REQ-017 DATA: at each count BIT_TICKS-1, shift rx_s into the shift register LSB-first and clear the counter; after the 8th sample move to STOP.
REQ-018 STOP: at count BIT_TICKS-1, if rx_s=1 load rx_data from the shift register, set rx_valid and go to IDLE.
REQ-019 STOP: if rx_s=0, pulse frame_err for exactly one cycle, leave rx_data and rx_valid unchanged, and go to BREAK.
REQ-020 BREAK: remain until rx_s=1, then go to IDLE; no start detection occurs in BREAK.
REQ-021 Byte completion while rx_valid=1 and rx_ack=0 SHALL overwrite rx_data and set rx_overrun.
REQ-022 rx_ack=1 without a simultaneous completion SHALL clear rx_valid and rx_overrun on the next edge.
REQ-023 rx_ack=1 in the same cycle as a completion SHALL leave rx_valid=1 with the new byte and leave rx_overrun=0.
REQ-024 rx_ack while rx_valid=0 SHALL have no effect.
REQ-025 Latency SHALL be fixed: rx_valid rises exactly 2 + HALF_TICKS + 9*BIT_TICKS cycles after the rx falling edge, plus at most 1 cycle of synchronizer phase.
REQ-026 The counter SHALL never wrap: it is cleared on every sample point and on every state entry.

Reset
REQ-027 While rst=1, outputs SHALL be rx_data=0x00, rx_valid=0, rx_overrun=0, frame_err=0, busy=0.
REQ-028 While rst=1, the FSM SHALL be in IDLE, the counter and shift register SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err; after release the FSM SHALL restart cleanly from IDLE.

Verification
REQ-030 Nominal byte: send 0xA5 at 9600 baud at defaults -> rx_data=0xA5, rx_valid rises 11877 +/-1 cycles after the start edge, frame_err never asserted.
REQ-031 Glitch rejection: drive rx low for 300 cycles then high -> FSM returns to IDLE, busy falls, no rx_valid or frame_err.
REQ-032 Overrun and ack: send 0x11 then 0x22 with no ack -> rx_data=0x22, rx_valid=1, rx_overrun=1; one rx_ack pulse -> both flags 0.
REQ-033 Simultaneous ack: assert rx_ack on the cycle 0x33 completes while 0x22 is pending -> rx_valid=1, rx_data=0x33, rx_overrun=0.
REQ-034 Framing and break: send 0x0F with stop bit low, hold rx low for 5000 cycles, release, then send 0x5A -> one frame_err pulse, rx_data unchanged until 0x5A, then rx_data=0x5A.
REQ-035 Reset mid-frame: assert rst during data bit 4 of 0x77, release, then send 0xC3 -> no outputs during the aborted frame, then rx_data=0xC3 with rx_valid=1.
